apb_slave_bank: RTL and testbench
=================================

Name: apb_slave_bank

Overview:
- Parametrised APB completer model with N independent register-file slaves. Each slave has a programmable wait-state count and generates address-range and alignment errors.
- Sits behind the AHB-to-APB bridge in place of passive stimulus. It drives PRDATA, PREADY and PSLVERR per slave from real sequential state, so directed and UVM tests can check wait-stated, errored and back-to-back APB traffic end to end.

Parameters:
- N, 8, number of slaves; one PSELx bit per slave.
- DATA_W, 32, width of PWDATA and of each slave's PRDATA.
- ADDR_W, 32, PADDR width.
- DEPTH, 16, words per slave register file; must be a power of 2 and at least 2.
- WAIT_W, 4, width of each slave's wait-state field.

Ports:
- clk  input  1  bus clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- PADDR  input  ADDR_W  byte address, shared by all slaves.
- PWDATA  input  DATA_W  write data, shared.
- PWRITE  input  1  1 = write, 0 = read.
- PENABLE  input  1  access-phase indicator.
- PSELx  input  N  per-slave select.
- cfg_wait  input  N*WAIT_W  wait states for slave i, in bits [i*WAIT_W +: WAIT_W]; sampled at setup.
- PRDATA  output  N*DATA_W  read data for slave i, in bits [i*DATA_W +: DATA_W].
- PREADY  output  N  per-slave ready.
- PSLVERR  output  N  per-slave error, valid only while PREADY[i] = 1.

Behaviour:
- Each slave i runs an independent FSM with states IDLE and ACCESS, a WAIT_W-bit down-counter, a latched address, a latched write flag and a DEPTH x DATA_W register file.
- All outputs decode from registered state only; there is no combinational path from the APB inputs to the outputs.
- Reset (rst = 1 at a clk edge): FSM -> IDLE, counter -> 0, all register-file words -> 0. Reset overrides any transfer in flight and no write commits in that cycle.
- Output values after reset: PREADY = 0, PSLVERR = 0, PRDATA = 0.
- IDLE -> ACCESS: on an edge with PSELx[i] = 1 and PENABLE = 0 (setup phase). On that edge latch PADDR and PWRITE, and load the counter from cfg_wait[i].
- ACCESS with counter > 0: PREADY[i] = 0. The counter decrements once per edge while PSELx[i] and PENABLE remain 1.
- ACCESS with counter = 0: PREADY[i] = 1. The transfer completes on the first edge with PSELx[i] = 1 and PENABLE = 1; the FSM then returns to IDLE.
- Latency: cfg_wait = k gives a transfer of 2 + k cycles (setup, plus k wait cycles, plus the final access cycle).
- Error condition, evaluated on the latched address:
  - err = (PADDR[1:0] != 0) OR (PADDR >= DEPTH*4).
  - PSLVERR[i] = err AND PREADY[i].
- Normal write (no error): at the completion edge, mem[PADDR[log2(DEPTH)+1:2]] <= PWDATA, using PWDATA sampled at that edge.
- Errored write: no memory update.
- Read: while PREADY[i] = 1 and the latched write flag is 0, PRDATA[i] = mem[latched index]. PRDATA[i] = 0 if err is set.
- PRDATA[i] = 0 in every other state.
- Back-to-back transfers: on the cycle after completion, PSELx[i] = 1 with PENABLE = 0 is a new setup, so there is no idle gap. A read immediately following a write to the same index returns the new data.
- PSELx[i] deasserted while in ACCESS (protocol violation): abort. FSM -> IDLE on that edge, no write, and outputs return to 0 on the next cycle.
- PENABLE = 1 in IDLE without a preceding setup: ignored, FSM stays in IDLE.
- Changes to cfg_wait[i] after setup have no effect on the transfer in progress.
- Multiple PSELx bits asserted together: each selected slave responds independently. No arbitration is performed; the bench flags this as a bridge error.

Test Plan:
- Zero-wait write then read, slave 2 (cfg_wait = 0): write 0xDEADBEEF at PADDR 0x8, then read 0x8. Expected: PREADY[2] = 1 in each access cycle, PRDATA[2] = 0xDEADBEEF, PSLVERR = 0, 2 cycles per transfer.
- Wait states, slave 5 (cfg_wait = 3): read at 0x4. Expected: PREADY[5] low for exactly 3 access cycles, then high; total transfer 5 cycles.
- Errors, slave 0, DEPTH = 16:
  - Write 0x12345678 to 0x40 (out of range). Expected: PSLVERR[0] = 1 with PREADY[0].
  - Read 0x0. Expected: still 0, confirming the write did not commit.
  - Read 0x6 (unaligned). Expected: PSLVERR[0] = 1, PRDATA[0] = 0.
- Back-to-back, slave 7: write 0xA5A5A5A5 to 0xC, then read 0xC with no idle cycle. Expected: PRDATA[7] = 0xA5A5A5A5, 4 cycles total.
- Abort and reset, slave 1 (cfg_wait = 5): start a write of 0x1 to 0x0 and drop PSELx[1] after 2 wait cycles. Expected: next cycle PREADY = 0, and a subsequent read of 0x0 returns 0.
  - Then write 0x77 to 0x0, assert rst mid-read of 0x0, and read again. Expected: returns 0.

Source files
------------

// File: rtl/apb_slave_bank_if.sv
// APB bus bundle for the slave bank: shared request lines, per-slave select
// and wait configuration, and flattened per-slave response lines.
interface apb_slave_bank_if #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int WAIT_W = 4
);
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic                PWRITE;
  logic                PENABLE;
  logic [N-1:0]        PSELx;
  logic [N*WAIT_W-1:0] cfg_wait;
  logic [N*DATA_W-1:0] PRDATA;
  logic [N-1:0]        PREADY;
  logic [N-1:0]        PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSELx, cfg_wait,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSELx, cfg_wait,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_bank.sv
// Bank of N independent APB register-file completers. Each lane latches its
// request at setup, counts down programmable wait states, then completes.
// Every output is decoded from lane state only, never from the live bus.

// One APB completer: IDLE/ACCESS FSM, wait counter, latched request, memory.
module apb_slave_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              pwrite,
  input  logic              penable,
  input  logic              psel,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  // Request as captured at setup; the error flag is resolved up front so
  // the access phase never looks at the live address.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             write;
    logic             err;
  } req_t;

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  req_t              req;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              addr_err;
  logic [IDX_W-1:0]  addr_idx;
  logic              ready_q;

  // Misaligned or beyond the last word of this lane's register file.
  assign addr_err = (paddr[1:0] != 2'b00) || (paddr >= ADDR_W'(DEPTH * 4));
  assign addr_idx = paddr[IDX_W+1:2];

  // Transfer state machine; reset also clears the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // PENABLE without a setup is ignored here.
          if (psel && !penable) begin
            state <= ACCESS;
            cnt   <= wait_cfg;
            req   <= '{idx: addr_idx, write: pwrite, err: addr_err};
          end
        end
        ACCESS: begin
          if (!psel) begin
            // Select dropped mid-transfer: abandon it, nothing is written.
            state <= IDLE;
          end else if (penable) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state <= IDLE;
              if (req.write && !req.err) mem[req.idx] <= pwdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_q = (state == ACCESS) && (cnt == '0);
  assign pready  = ready_q;
  assign pslverr = ready_q && req.err;
  assign prdata  = (ready_q && !req.write && !req.err) ? mem[req.idx] : '0;
endmodule

// Top: fans the shared bus out to N lanes and packs the responses back.
module apb_slave_bank #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  apb_slave_bank_if.slave bus
);
  logic [N-1:0][WAIT_W-1:0] wait_cfg;
  logic [N-1:0][DATA_W-1:0] prdata;
  logic [N-1:0]             pready;
  logic [N-1:0]             pslverr;

  assign wait_cfg = bus.cfg_wait;

  for (genvar i = 0; i < N; i++) begin : g_lane
    apb_slave_lane #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH),
      .WAIT_W(WAIT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .paddr   (bus.PADDR),
      .pwdata  (bus.PWDATA),
      .pwrite  (bus.PWRITE),
      .penable (bus.PENABLE),
      .psel    (bus.PSELx[i]),
      .wait_cfg(wait_cfg[i]),
      .prdata  (prdata[i]),
      .pready  (pready[i]),
      .pslverr (pslverr[i])
    );
  end

  assign bus.PRDATA  = prdata;
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pslverr;
endmodule

// File: tb/tb_apb_slave_bank.sv
// Scenario bench for apb_slave_bank: directed cases plus randomized traffic
// checked against an array model of every slave's register file.
module tb_apb_slave_bank;
  localparam int N = 8, DATA_W = 32, ADDR_W = 32, DEPTH = 16, WAIT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_slave_bank_if #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W)) bus_if ();

  apb_slave_bank #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_W(WAIT_W))
    dut (.clk(clk), .rst(rst), .bus(bus_if));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [N][DEPTH];

  function automatic bit exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  task automatic clear_model();
    for (int s = 0; s < N; s++)
      for (int w = 0; w < DEPTH; w++) model[s][w] = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus_if.PSELx = '0; bus_if.PENABLE = 1'b0;
    tick();
  endtask

  // Drive one full transfer on slave s. Reports cycles spent (setup included),
  // cycles with PREADY low, captured read data/error, whether any response
  // leaked out while not ready, and whether the wait bound expired.
  task automatic xfer(input int s, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int waits,
                      output int cycles, output int lows, output logic [31:0] rdata,
                      output logic err, output bit leak, output bit tmo);
    cycles = 0; lows = 0; rdata = '0; err = 1'b0; leak = 1'b0; tmo = 1'b0;
    bus_if.cfg_wait[s*WAIT_W +: WAIT_W] = WAIT_W'(waits);
    bus_if.PSELx = '0; bus_if.PSELx[s] = 1'b1;
    bus_if.PENABLE = 1'b0; bus_if.PADDR = addr; bus_if.PWRITE = wr;
    bus_if.PWDATA = ~wdata;  // only the completion-edge value may land
    tick();
    cycles = 1;
    bus_if.cfg_wait[s*WAIT_W +: WAIT_W] = WAIT_W'($urandom_range(0, 15));
    bus_if.PENABLE = 1'b1; bus_if.PWDATA = wdata;
    for (int k = 0; k < 40; k++) begin
      cycles++;
      if (bus_if.PREADY[s]) begin
        rdata = bus_if.PRDATA[s*DATA_W +: DATA_W];
        err   = bus_if.PSLVERR[s];
        tick();
        return;
      end
      lows++;
      if (bus_if.PSLVERR[s] || bus_if.PRDATA[s*DATA_W +: DATA_W] != '0) leak = 1'b1;
      tick();
    end
    tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.PSELx = '0; bus_if.PENABLE = 1'b0; bus_if.PWRITE = 1'b0;
    bus_if.PADDR = '0; bus_if.PWDATA = '0; bus_if.cfg_wait = '0;
    tick(); tick();
    rst = 1'b0;
    clear_model();
    tick();
    n_checks++; if (bus_if.PREADY !== '0) begin n_fail++; $display("FAIL rst_pready: got %0h want 0", bus_if.PREADY); end
    n_checks++; if (bus_if.PSLVERR !== '0) begin n_fail++; $display("FAIL rst_pslverr: got %0h want 0", bus_if.PSLVERR); end
    n_checks++; if (bus_if.PRDATA !== '0) begin n_fail++; $display("FAIL rst_prdata: got %0h want 0", bus_if.PRDATA); end
  endtask

  task automatic test_zero_wait();
    int cyc, lows; logic [31:0] rd; logic er; bit lk, to;
    xfer(2, 1'b1, 32'h8, 32'hDEADBEEF, 0, cyc, lows, rd, er, lk, to);
    model[2][2] = 32'hDEADBEEF;
    n_checks++; if (to || cyc != 2) begin n_fail++; $display("FAIL zw_wr_cycles: got %0d want 2", cyc); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL zw_wr_err: got %0b want 0", er); end
    xfer(2, 1'b0, 32'h8, 32'h0, 0, cyc, lows, rd, er, lk, to);
    n_checks++; if (to || cyc != 2) begin n_fail++; $display("FAIL zw_rd_cycles: got %0d want 2", cyc); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_rd_data: got %08h want deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL zw_rd_err: got %0b want 0", er); end
    idle();
  endtask

  task automatic test_wait_states();
    int cyc, lows; logic [31:0] rd; logic er; bit lk, to;
    xfer(5, 1'b1, 32'h4, 32'h0BADF00D, 2, cyc, lows, rd, er, lk, to);
    model[5][1] = 32'h0BADF00D;
    idle();
    xfer(5, 1'b0, 32'h4, 32'h0, 3, cyc, lows, rd, er, lk, to);
    n_checks++; if (to || lows != 3) begin n_fail++; $display("FAIL ws_low_cycles: got %0d want 3", lows); end
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL ws_total_cycles: got %0d want 5", cyc); end
    n_checks++; if (lk) begin n_fail++; $display("FAIL ws_leak: got 1 want 0"); end
    n_checks++; if (rd !== model[5][1]) begin n_fail++; $display("FAIL ws_rd_data: got %08h want %08h", rd, model[5][1]); end
    idle();
  endtask

  task automatic test_errors();
    int cyc, lows; logic [31:0] rd; logic er; bit lk, to;
    xfer(0, 1'b1, 32'h40, 32'h12345678, 0, cyc, lows, rd, er, lk, to);
    n_checks++; if (to || er !== 1'b1) begin n_fail++; $display("FAIL err_range_wr: got %0b want 1", er); end
    xfer(0, 1'b0, 32'h0, 32'h0, 0, cyc, lows, rd, er, lk, to);
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL err_no_commit: got %08h/%0b want 0/0", rd, er); end
    xfer(0, 1'b0, 32'h6, 32'h0, 1, cyc, lows, rd, er, lk, to);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_unaligned: got %0b want 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_unaligned_data: got %08h want 0", rd); end
    n_checks++; if (lk) begin n_fail++; $display("FAIL err_leak: got 1 want 0"); end
    idle();
  endtask

  task automatic test_back_to_back();
    int c1, c2, lows; logic [31:0] rd; logic er; bit lk, to1, to2;
    xfer(7, 1'b1, 32'hC, 32'hA5A5A5A5, 0, c1, lows, rd, er, lk, to1);
    xfer(7, 1'b0, 32'hC, 32'h0, 0, c2, lows, rd, er, lk, to2);
    model[7][3] = 32'hA5A5A5A5;
    n_checks++; if (to1 || to2 || c1 + c2 != 4) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 4", c1 + c2); end
    n_checks++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_data: got %08h want a5a5a5a5", rd); end
    idle();
  endtask

  task automatic test_abort_reset();
    int cyc, lows; logic [31:0] rd; logic er; bit lk, to;
    bus_if.cfg_wait[1*WAIT_W +: WAIT_W] = 4'd5;
    bus_if.PSELx = 8'b0000_0010; bus_if.PENABLE = 1'b0;
    bus_if.PADDR = 32'h0; bus_if.PWRITE = 1'b1; bus_if.PWDATA = 32'h1;
    tick();
    bus_if.PENABLE = 1'b1;
    tick(); tick();
    n_checks++; if (bus_if.PREADY[1] !== 1'b0) begin n_fail++; $display("FAIL abort_mid_wait: got %0b want 0", bus_if.PREADY[1]); end
    bus_if.PSELx = '0; bus_if.PENABLE = 1'b0;
    tick();
    n_checks++; if (bus_if.PREADY[1] !== 1'b0) begin n_fail++; $display("FAIL abort_pready: got %0b want 0", bus_if.PREADY[1]); end
    xfer(1, 1'b0, 32'h0, 32'h0, 0, cyc, lows, rd, er, lk, to);
    n_checks++; if (to || cyc != 2) begin n_fail++; $display("FAIL abort_idle_cycles: got %0d want 2", cyc); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_no_write: got %08h want 0", rd); end
    xfer(1, 1'b1, 32'h0, 32'h77, 0, cyc, lows, rd, er, lk, to);
    model[1][0] = 32'h77;
    idle();
    bus_if.cfg_wait[1*WAIT_W +: WAIT_W] = 4'd3;
    bus_if.PSELx = 8'b0000_0010; bus_if.PENABLE = 1'b0; bus_if.PWRITE = 1'b0;
    tick();
    bus_if.PENABLE = 1'b1;
    tick();
    rst = 1'b1; bus_if.PSELx = '0; bus_if.PENABLE = 1'b0;
    tick();
    rst = 1'b0;
    clear_model();
    n_checks++; if (bus_if.PREADY !== '0 || bus_if.PRDATA !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %0h/%0h want 0/0", bus_if.PREADY, bus_if.PRDATA); end
    xfer(1, 1'b0, 32'h0, 32'h0, 0, cyc, lows, rd, er, lk, to);
    n_checks++; if (to || rd !== model[1][0]) begin n_fail++; $display("FAIL midrst_read: got %08h want %08h", rd, model[1][0]); end
    idle();
  endtask

  task automatic test_multi_select();
    int rdy3, rdy4, cyc, lows; logic [31:0] rd; logic er; bit lk, to;
    rdy3 = -1; rdy4 = -1;
    bus_if.cfg_wait[3*WAIT_W +: WAIT_W] = 4'd0;
    bus_if.cfg_wait[4*WAIT_W +: WAIT_W] = 4'd2;
    bus_if.PSELx = 8'b0001_1000; bus_if.PENABLE = 1'b0;
    bus_if.PADDR = 32'h10; bus_if.PWRITE = 1'b1; bus_if.PWDATA = 32'hC0FFEE11;
    tick();
    bus_if.PENABLE = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (rdy3 < 0 && bus_if.PREADY[3]) rdy3 = k;
      if (rdy4 < 0 && bus_if.PREADY[4]) rdy4 = k;
      tick();
    end
    idle();
    model[3][4] = 32'hC0FFEE11; model[4][4] = 32'hC0FFEE11;
    n_checks++; if (rdy3 != 1) begin n_fail++; $display("FAIL multi_ready3: got %0d want 1", rdy3); end
    n_checks++; if (rdy4 != 3) begin n_fail++; $display("FAIL multi_ready4: got %0d want 3", rdy4); end
    xfer(3, 1'b0, 32'h10, 32'h0, 0, cyc, lows, rd, er, lk, to);
    n_checks++; if (rd !== model[3][4]) begin n_fail++; $display("FAIL multi_rd3: got %08h want %08h", rd, model[3][4]); end
    xfer(4, 1'b0, 32'h10, 32'h0, 1, cyc, lows, rd, er, lk, to);
    n_checks++; if (rd !== model[4][4]) begin n_fail++; $display("FAIL multi_rd4: got %08h want %08h", rd, model[4][4]); end
    idle();
  endtask

  task automatic test_random();
    int s, waits, cyc, lows; bit wr, e, lk, to; logic [31:0] addr, wdata, rd, want; logic er;
    for (int it = 0; it < 80; it++) begin
      s = $urandom_range(0, N - 1);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) addr = 32'($urandom_range(0, 127));
      else addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
      waits = $urandom_range(0, 4);
      wdata = $urandom;
      e = exp_err(addr);
      xfer(s, wr, addr, wdata, waits, cyc, lows, rd, er, lk, to);
      n_checks++; if (to || cyc != 2 + waits || lows != waits) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, cyc, 2 + waits); end
      n_checks++; if (er !== e) begin n_fail++; $display("FAIL rnd_err[%0d]: got %0b want %0b addr %0h", it, er, e, addr); end
      n_checks++; if (lk) begin n_fail++; $display("FAIL rnd_leak[%0d]: got 1 want 0", it); end
      if (!wr) begin
        if (e) want = '0; else want = model[s][addr / 4];
        n_checks++; if (rd !== want) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %08h want %08h s%0d addr %0h", it, rd, want, s, addr); end
      end else if (!e) begin
        model[s][addr / 4] = wdata;
      end
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_abort_reset();
    test_multi_select();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
